// File: rtl/sign_zero_extend.sv
// RISC-V immediate generator: registers the U/J/I/S/B immediates of an instruction word.
// Optional macro SIGN_ZERO_EXTEND_IMM_MUX_EN adds IMM_SEL/IMM_OUT, a registered format-select output.
module sign_zero_extend #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EN,
  input  logic            ZERO_EXT,
  input  logic [XLEN-1:0] INSTRUCTION,
`ifdef SIGN_ZERO_EXTEND_IMM_MUX_EN
  input  logic [2:0]      IMM_SEL,
  output logic [XLEN-1:0] IMM_OUT,
`endif
  output logic [XLEN-1:0] U_TYPE,
  output logic [XLEN-1:0] J_TYPE,
  output logic [XLEN-1:0] I_TYPE,
  output logic [XLEN-1:0] S_TYPE,
  output logic [XLEN-1:0] B_TYPE
);

  function automatic logic ext_bit(input logic [XLEN-1:0] instr, input logic zext);
    return zext ? 1'b0 : instr[31];
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [XLEN-1:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_i(input logic [XLEN-1:0] instr, input logic zext);
    return {{20{ext_bit(instr, zext)}}, instr[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [XLEN-1:0] instr, input logic zext);
    return {{20{ext_bit(instr, zext)}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] instr, input logic zext);
    return {{19{ext_bit(instr, zext)}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] instr, input logic zext);
    return {{11{ext_bit(instr, zext)}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  logic [XLEN-1:0] u_p0, j_p0, i_p0, s_p0, b_p0;
  logic [XLEN-1:0] u_p1, j_p1, i_p1, s_p1, b_p1;

  // Stage p0: combinational slicing of the raw instruction word
  always_comb begin
    u_p0 = imm_u(INSTRUCTION);
    j_p0 = imm_j(INSTRUCTION, ZERO_EXT);
    i_p0 = imm_i(INSTRUCTION, ZERO_EXT);
    s_p0 = imm_s(INSTRUCTION, ZERO_EXT);
    b_p0 = imm_b(INSTRUCTION, ZERO_EXT);
  end

  // Stage p1: decode-boundary registers, held while EN is low
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      u_p1 <= '0;
      j_p1 <= '0;
      i_p1 <= '0;
      s_p1 <= '0;
      b_p1 <= '0;
    end else if (EN) begin
      u_p1 <= u_p0;
      j_p1 <= j_p0;
      i_p1 <= i_p0;
      s_p1 <= s_p0;
      b_p1 <= b_p0;
    end
  end

  assign U_TYPE = u_p1;
  assign J_TYPE = j_p1;
  assign I_TYPE = i_p1;
  assign S_TYPE = s_p1;
  assign B_TYPE = b_p1;

`ifdef SIGN_ZERO_EXTEND_IMM_MUX_EN
  logic [XLEN-1:0] imm_p0, imm_p1;

  // Selection uses the same p0 values so IMM_OUT lines up with the per-format outputs
  always_comb begin
    imm_p0 = '0;
    case (IMM_SEL)
      3'd0:    imm_p0 = i_p0;
      3'd1:    imm_p0 = s_p0;
      3'd2:    imm_p0 = b_p0;
      3'd3:    imm_p0 = u_p0;
      3'd4:    imm_p0 = j_p0;
      default: imm_p0 = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)   imm_p1 <= '0;
    else if (EN) imm_p1 <= imm_p0;
  end

  assign IMM_OUT = imm_p1;
`endif

endmodule

// File: tb/tb_sign_zero_extend.sv
// Scoreboard bench for sign_zero_extend: driver queues hand-computed immediates, monitor checks them.
module tb_sign_zero_extend;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        EN = 1'b0;
  logic        ZERO_EXT = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic [31:0] U_TYPE, J_TYPE, I_TYPE, S_TYPE, B_TYPE;
  logic [2:0]  IMM_SEL = '0;
  logic [31:0] IMM_OUT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] u, j, i, s, b, imm;
  } exp_t;

  exp_t sb_q[$];

  sign_zero_extend #(.XLEN(32)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .EN(EN),
    .ZERO_EXT(ZERO_EXT),
    .INSTRUCTION(INSTRUCTION),
`ifdef SIGN_ZERO_EXTEND_IMM_MUX_EN
    .IMM_SEL(IMM_SEL),
    .IMM_OUT(IMM_OUT),
`endif
    .U_TYPE(U_TYPE),
    .J_TYPE(J_TYPE),
    .I_TYPE(I_TYPE),
    .S_TYPE(S_TYPE),
    .B_TYPE(B_TYPE)
  );

`ifndef SIGN_ZERO_EXTEND_IMM_MUX_EN
  assign IMM_OUT = '0;
`endif

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e, input bit with_imm);
    check({tag, ".U"}, U_TYPE, e.u);
    check({tag, ".J"}, J_TYPE, e.j);
    check({tag, ".I"}, I_TYPE, e.i);
    check({tag, ".S"}, S_TYPE, e.s);
    check({tag, ".B"}, B_TYPE, e.b);
    if (with_imm) check({tag, ".IMM"}, IMM_OUT, e.imm);
  endtask

  // Monitor: one output word per clock edge, compared after the edge settles
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
`ifdef SIGN_ZERO_EXTEND_IMM_MUX_EN
        check_all("edge", e, 1'b1);
`else
        check_all("edge", e, 1'b0);
`endif
      end
    end
  end

  task automatic drive(input logic en, input logic zext, input logic [31:0] instr,
                       input logic [2:0] sel, input exp_t e);
    @(negedge CLK);
    EN = en;
    ZERO_EXT = zext;
    INSTRUCTION = instr;
    IMM_SEL = sel;
    sb_q.push_back(e);
  endtask

  function automatic exp_t mk(input logic [31:0] u, j, i, s, b, imm);
    exp_t e;
    e.u = u; e.j = j; e.i = i; e.s = s; e.b = b; e.imm = imm;
    return e;
  endfunction

  initial begin
    exp_t zero, va_s, vb_s, va_z, e;
    logic [31:0] sel_exp [8];
    zero = mk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    va_s = mk(32'hAE575000, 32'hFFF75AE4, 32'hFFFFFAE5, 32'hFFFFFAEA, 32'hFFFFF2EA, 32'hFFFFFAE5);
    vb_s = mk(32'h54946000, 32'h00046D48, 32'h00000549, 32'h0000055F, 32'h00000D5E, 32'h00000549);
    va_z = mk(32'hAE575000, 32'h00175AE4, 32'h00000AE5, 32'h00000AEA, 32'h000012EA, 32'h00000AE5);
    sel_exp = '{32'hFFFFFAE5, 32'hFFFFFAEA, 32'hFFFFF2EA, 32'hAE575000, 32'hFFF75AE4,
                32'h0, 32'h0, 32'h0};

    // Asynchronous reset before any clock edge
    #1 RESET = 1'b1;
    #2 check_all("async_reset", zero, 1'b1);
    @(negedge CLK);
    RESET = 1'b0;
    drive(1'b0, 1'b0, 32'hAE57557A, 3'd0, zero);

    drive(1'b1, 1'b0, 32'hAE57557A, 3'd0, va_s);
    drive(1'b1, 1'b0, 32'h54946FBB, 3'd0, vb_s);
    drive(1'b1, 1'b1, 32'hAE57557A, 3'd0, va_z);
    drive(1'b1, 1'b1, 32'h54946FBB, 3'd0, vb_s);

    // Stall: outputs hold the last captured word
    drive(1'b1, 1'b0, 32'h54946FBB, 3'd0, vb_s);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 32'hFFFFFFFF, 3'd4, vb_s);

    // Mid-cycle reset clears without a clock edge
    @(posedge CLK);
    #3 RESET = 1'b1;
    #1 check_all("mid_reset", zero, 1'b1);
    @(negedge CLK);
    RESET = 1'b0;

    drive(1'b1, 1'b0, 32'hAE57557A, 3'd0, va_s);
    // Reset held across an enabled edge keeps outputs at zero
    @(negedge CLK);
    RESET = 1'b1;
    EN = 1'b1;
    INSTRUCTION = 32'h54946FBB;
    sb_q.push_back(zero);
    @(negedge CLK);
    RESET = 1'b0;

`ifdef SIGN_ZERO_EXTEND_IMM_MUX_EN
    for (int s = 0; s < 8; s++) begin
      e = va_s;
      e.imm = sel_exp[s];
      drive(1'b1, 1'b0, 32'hAE57557A, 3'(s), e);
    end
`endif

    // Let the monitor drain the scoreboard, bounded
    for (int c = 0; c < 20 && sb_q.size() > 0; c++) @(posedge CLK);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
